// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it out
// as start bit, data LSB first, optional parity, then one or two stop bits.
module uart_tx #(
  parameter int p_CLK_PER_BIT = 16,
  parameter int p_DATA_WIDTH  = 8,
  parameter int p_PARITY      = 0,
  parameter int p_STOP_BITS   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [p_DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_tx,
  output logic                    o_busy,
  output logic [2:0]              o_state
);

  if (p_CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
    $error("uart_tx: p_CLK_PER_BIT must be 2 or more");
  end
  if (p_DATA_WIDTH < 5 || p_DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx: p_DATA_WIDTH must be in 5..9");
  end
  if (p_PARITY < 0 || p_PARITY > 2) begin : g_bad_parity
    $error("uart_tx: p_PARITY must be 0, 1 or 2");
  end
  if (p_STOP_BITS < 1 || p_STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: p_STOP_BITS must be 1 or 2");
  end

  localparam int DIV_W = (p_CLK_PER_BIT > 1) ? $clog2(p_CLK_PER_BIT) : 1;
  localparam int IDX_W = (p_DATA_WIDTH > 2) ? $clog2(p_DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(p_CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(p_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(p_STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Handshake: a word is taken on a rising edge where i_valid and o_ready are
  // both high; the producer holds i_valid and i_data stable until then.
  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [p_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    bit_end;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_end = (div_q == DIV_LAST);
    if (state_q == S_IDLE) begin
      div_d = '0;
      idx_d = '0;
      if (i_valid) begin
        shift_d = i_data;
        // Parity is frozen with the word so later i_data changes cannot leak in.
        par_d   = (p_PARITY == 2) ? ~(^i_data) : (^i_data);
        state_d = S_START;
      end
    end else begin
      div_d = bit_end ? '0 : div_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            idx_d   = '0;
          end
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (idx_q == DATA_LAST) begin
              idx_d   = '0;
              state_d = (p_PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            idx_d   = '0;
          end
          S_STOP: begin
            if (idx_q == STOP_LAST) begin
              state_d = S_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // The line is registered from the next state so it changes with the state.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    o_tx    = tx_q;
    o_busy  = (state_q != S_IDLE);
    o_ready = (state_q == S_IDLE) & ~i_reset;
    o_state = state_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even parity, odd parity, two stop
// bits), table-driven frame vectors plus hand-written corner-case sequences.
module tb_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic [3:0]  rst_r;
  logic [3:0]  valid_r;
  logic [7:0]  data_r [4];
  logic [3:0]  ready_w, tx_w, busy_w;
  logic [11:0] st_w;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    int          k;
    logic [7:0]  d;
    int          nbits;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_tx #(.p_CLK_PER_BIT(CPB)) u_dut0 (
    .i_clk(clk), .i_reset(rst_r[0]), .i_data(data_r[0]), .i_valid(valid_r[0]),
    .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_state(st_w[2:0]));
  uart_tx #(.p_CLK_PER_BIT(CPB), .p_PARITY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_r[1]), .i_data(data_r[1]), .i_valid(valid_r[1]),
    .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_state(st_w[5:3]));
  uart_tx #(.p_CLK_PER_BIT(CPB), .p_PARITY(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_r[2]), .i_data(data_r[2]), .i_valid(valid_r[2]),
    .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_state(st_w[8:6]));
  uart_tx #(.p_CLK_PER_BIT(CPB), .p_STOP_BITS(2)) u_dut3 (
    .i_clk(clk), .i_reset(rst_r[3]), .i_data(data_r[3]), .i_valid(valid_r[3]),
    .o_ready(ready_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]), .o_state(st_w[11:9]));

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] dec(input logic [63:0] ts);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ts[(1 + i) * CPB + CPB / 2];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [7:0] d, output int hs);
    @(negedge clk);
    valid_r[k] = 1'b1;
    data_r[k]  = d;
    for (int t = 0; t < 200 && !ready_w[k]; t++) @(negedge clk);
    hs = cyc;
    @(posedge clk);
    @(negedge clk);
    valid_r[k] = 1'b0;
  endtask

  // Waits for a start edge, then records one sample per cycle for the frame.
  task automatic capture(input int k, input int nbits, output logic [63:0] ts,
                         output logic [63:0] bs, output int sc, output bit found);
    found = 1'b0;
    ts = '1;
    bs = '0;
    sc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tx_w[k] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      sc = cyc;
      ts[0] = tx_w[k];
      bs[0] = busy_w[k];
      for (int j = 1; j < nbits * CPB; j++) begin
        @(negedge clk);
        ts[j] = tx_w[k];
        bs[j] = busy_w[k];
      end
    end
  endtask

  task automatic run_frame(input int k, input logic [7:0] d, input int nbits,
                           input logic [10:0] exp);
    int hs, sc, bad;
    bit found;
    logic [63:0] ts, bs;
    fork
      send(k, d, hs);
      capture(k, nbits, ts, bs, sc, found);
    join
    chk($sformatf("start_found_k%0d", k), 32'(found), 32'd1);
    chk($sformatf("start_latency_k%0d", k), 32'(sc - hs), 32'd1);
    for (int i = 0; i < nbits; i++)
      chk($sformatf("bit%0d_k%0d_d%02h", i, k, d), 32'(ts[i * CPB +: CPB]),
          exp[i] ? 32'hF : 32'h0);
    bad = 0;
    for (int j = 0; j < nbits * CPB; j++) if (!bs[j]) bad++;
    chk($sformatf("busy_low_cycles_k%0d", k), 32'(bad), 32'd0);
    @(negedge clk);
    chk($sformatf("post_ready_k%0d", k), 32'(ready_w[k]), 32'd1);
    chk($sformatf("post_busy_k%0d", k), 32'(busy_w[k]), 32'd0);
    chk($sformatf("post_tx_k%0d", k), 32'(tx_w[k]), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int hs, sc1, sc2, bad, ferr;
    bit f1, f2;
    logic [63:0] ts1, bs1, ts2, bs2;

    // time order: bit 0 is the start bit, the MSB is the last stop bit
    vecs[0] = '{0, 8'h55, 10, 11'b000_1010_1010 | 11'h200};
    vecs[1] = '{0, 8'h00, 10, 11'b010_0000_0000};
    vecs[2] = '{0, 8'hFF, 10, 11'b011_1111_1110};
    vecs[3] = '{1, 8'h07, 11, 11'b110_0000_1110};
    vecs[4] = '{2, 8'h07, 11, 11'b100_0000_1110};
    vecs[5] = '{1, 8'h00, 11, 11'b100_0000_0000};
    vecs[6] = '{2, 8'h00, 11, 11'b110_0000_0000};
    vecs[7] = '{3, 8'hA3, 11, 11'b111_0100_0110};

    rst_r   = 4'hF;
    valid_r = 4'h0;
    for (int k = 0; k < 4; k++) data_r[k] = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_ready_k%0d", k), 32'(ready_w[k]), 32'd0);
      chk($sformatf("reset_tx_k%0d", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("reset_busy_k%0d", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("reset_state_k%0d", k), 32'(st_w[k * 3 +: 3]), 32'd0);
    end
    rst_r = 4'h0;
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("ready_after_reset_k%0d", k), 32'(ready_w[k]), 32'd1);

    foreach (vecs[v]) run_frame(vecs[v].k, vecs[v].d, vecs[v].nbits, vecs[v].exp);

    // two stop bits, i_valid held across a back-to-back handshake
    @(negedge clk);
    valid_r[3] = 1'b1;
    data_r[3]  = 8'hA3;
    fork
      begin
        @(posedge clk);
        @(negedge clk);
        data_r[3] = 8'h3C;
        for (int t = 0; t < 200 && !ready_w[3]; t++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        valid_r[3] = 1'b0;
      end
      begin
        capture(3, 11, ts1, bs1, sc1, f1);
        capture(3, 11, ts2, bs2, sc2, f2);
      end
    join
    chk("b2b_found", {30'd0, f1, f2}, 32'd3);
    chk("b2b_byte1", 32'(dec(ts1)), 32'hA3);
    chk("b2b_byte2", 32'(dec(ts2)), 32'h3C);
    chk("b2b_stop1_8cyc", 32'(ts1[9 * CPB +: 2 * CPB]), 32'hFF);
    chk("b2b_stop2_8cyc", 32'(ts2[9 * CPB +: 2 * CPB]), 32'hFF);
    chk("b2b_start_spacing", 32'(sc2 - sc1), 32'd45);
    repeat (2) @(negedge clk);

    // i_data change after acceptance and i_valid pulses mid-frame are ignored
    @(negedge clk);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'hF0;
    fork
      begin
        @(posedge clk);
        @(negedge clk);
        data_r[0]  = 8'h0F;
        valid_r[0] = 1'b0;
        repeat (5) @(negedge clk);
        valid_r[0] = 1'b1;
        repeat (3) @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (10) @(negedge clk);
        valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
      end
      capture(0, 10, ts1, bs1, sc1, f1);
    join
    chk("hold_found", 32'(f1), 32'd1);
    chk("hold_byte", 32'(dec(ts1)), 32'hF0);
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (!tx_w[0] || busy_w[0]) bad++;
    end
    chk("hold_no_extra_frame", 32'(bad), 32'd0);

    // reset during data bit 3 aborts the frame
    send(0, 8'h00, hs);
    repeat (17) @(negedge clk);
    chk("midreset_tx_before", 32'(tx_w[0]), 32'd0);
    rst_r[0] = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_w[0]), 32'd1);
    chk("midreset_busy", 32'(busy_w[0]), 32'd0);
    chk("midreset_ready", 32'(ready_w[0]), 32'd1);
    run_frame(0, 8'h81, 10, 11'b011_0000_0010);

    // reset and valid together: nothing is accepted
    @(negedge clk);
    rst_r[1]   = 1'b1;
    valid_r[1] = 1'b1;
    data_r[1]  = 8'hFF;
    #1;
    chk("rst_valid_ready", 32'(ready_w[1]), 32'd0);
    @(negedge clk);
    rst_r[1]   = 1'b0;
    valid_r[1] = 1'b0;
    bad = 0;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (!tx_w[1] || busy_w[1]) bad++;
    end
    chk("rst_valid_not_accepted", 32'(bad), 32'd0);

    // loopback of every byte value through the bench receiver
    ferr = 0;
    for (int b = 0; b < 256; b++) begin
      logic [7:0] bv;
      bv = b[7:0];
      exp_q.push_back(bv);
      fork
        send(0, bv, hs);
        capture(0, 10, ts1, bs1, sc1, f1);
      join
      if (!f1 || ts1[CPB / 2] != 1'b0 || ts1[9 * CPB + CPB / 2] != 1'b1) ferr++;
      chk($sformatf("loop_byte_%02h", bv), 32'(dec(ts1)), 32'(exp_q.pop_front()));
    end
    chk("loop_framing_errors", 32'(ferr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the UART receive path (sample generator + shift accumulator) in lib/protocol.
- Accepts a parallel word over a valid/ready handshake and serialises it on a single line: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from an internal clock divider, so no external baud strobe is needed.
- Sits between a byte producer (FIFO, command engine) and the pad.

Parameters:
- p_CLK_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
- p_DATA_WIDTH, 8, data bits per frame; legal range is 5 to 9.
- p_PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- p_STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_data  input  p_DATA_WIDTH  word to transmit; sampled only on handshake.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  transmitter can accept a word this cycle.
- o_tx  output  1  serial line; idle/mark level is 1.
- o_busy  output  1  a frame is in progress, from the first start-bit cycle to the last stop-bit cycle.

Interface decision: one clock, i_clk. Reset i_reset is synchronous and active-high.

Behaviour:
- Reset:
  - While i_reset is high at a rising edge, the block enters IDLE and clears the bit counter and divider.
  - Outputs in/after reset: o_tx=1 (registered), o_busy=0.
  - o_ready = (state==IDLE) & ~i_reset, so it is 0 during reset and 1 in the first cycle after i_reset falls.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1, o_ready=1.
  - Handshake happens when i_valid & o_ready are both high at a rising edge.
  - On handshake, i_data is latched into a shift register, the state moves to START and the divider is cleared.
  - If i_valid is low, the block stays in IDLE.
- Latency: o_tx goes to 0 in the cycle immediately after the handshake edge. o_busy rises in the same cycle.
- Bit period:
  - Every bit (start, data, parity, stop) holds o_tx stable for exactly p_CLK_PER_BIT cycles.
  - The divider counts 0..p_CLK_PER_BIT-1. The state or bit advances when the divider reaches the terminal count. The divider wraps to 0.
  - Divider width is $clog2(p_CLK_PER_BIT).
- START: o_tx=0 for one bit period, then DATA with bit index 0.
- DATA:
  - o_tx = shift_reg[0]. At the end of each bit period, shift right and increment the index.
  - After bit p_DATA_WIDTH-1, go to PARITY if p_PARITY != 0, else to STOP.
- PARITY:
  - Even mode: o_tx = XOR of the latched data. Odd mode: o_tx = the inverse of that XOR.
  - Parity is computed from the latched word, never from live i_data.
  - One bit period, then STOP.
- STOP:
  - o_tx=1 for p_STOP_BITS bit periods.
  - After the last one, return to IDLE. o_busy=0 and o_ready=1 in that next cycle.
- Frame length: p_CLK_PER_BIT*(1+p_DATA_WIDTH+(p_PARITY!=0)+p_STOP_BITS) cycles.
- Back-to-back frames: the minimum spacing between consecutive start-bit falling edges is frame length + 1 cycle, because of one IDLE cycle.
- Boundary cases:
  - i_valid asserted during a frame is ignored. The producer must hold i_valid until o_ready.
  - Changes to i_data after the handshake do not affect the frame in flight.
  - Reset mid-frame aborts immediately. o_tx=1 from the next cycle, the latched word is discarded, and there is no partial stop bit.
  - i_valid and i_reset high together: reset wins, nothing is accepted.
  - Illegal parameter values must trigger an elaboration-time $error.

Test Plan:
- Basic frame: defaults with p_CLK_PER_BIT=4. Send 0x55 -> o_tx is 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each held exactly 4 cycles. The frame totals 40 cycles with o_busy high throughout, and o_ready returns on cycle 41.
- Parity: p_PARITY=1, send 0x07 -> parity bit 1. p_PARITY=2, send 0x07 -> parity bit 0. p_PARITY=1, send 0x00 -> parity bit 0. The frame is 11 bit periods.
- Two stop bits with a back-to-back handshake: p_STOP_BITS=2, i_valid held high with 0xA3 then 0x3C. Required:
  - o_tx stays 1 for 8 cycles after the last data bit.
  - The second start edge falls exactly 45 cycles after the first.
  - Both bytes are decoded correctly by the existing UART RX.
- Handshake hold: change i_data from 0xF0 to 0x0F on the cycle after acceptance -> the line still carries 0xF0. i_valid pulses during the frame are not accepted.
- Mid-frame reset: assert i_reset for 1 cycle during data bit 3 of 0x00 -> o_tx=1 on the next cycle, o_busy=0, o_ready=1 after reset falls. A following 0x81 transmits cleanly.
- Loopback: connect o_tx to the existing UART RX with a matching bit period, then send 256 sequential bytes 0x00..0xFF -> all are received in order with no framing errors. The run finishes with `assert_pass.
